// File: rtl/incubator_pkg.sv
// rtl/incubator_pkg.sv - shared mode encodings, widths and default limits
package incubator_pkg;

  typedef logic [1:0] mode_t;

  localparam int TEMP_W = 8;
  localparam int CALC_W = 10;

  localparam mode_t MODE_DRIFT = 2'd0;
  localparam mode_t MODE_HEAT  = 2'd1;
  localparam mode_t MODE_COOL  = 2'd2;
  localparam mode_t MODE_FAULT = 2'd3;

  localparam int DEF_T_MIN   = -40;
  localparam int DEF_T_MAX   = 100;
  localparam int DEF_AMBIENT = 25;

  // Saturate a widened intermediate into the registered temperature range.
  function automatic logic signed [TEMP_W-1:0] clamp_temp(
    input logic signed [CALC_W-1:0] v,
    input logic signed [CALC_W-1:0] lo,
    input logic signed [CALC_W-1:0] hi
  );
    logic signed [CALC_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r[TEMP_W-1:0];
  endfunction

endpackage

// File: rtl/incubator_tick_gen.sv
// rtl/incubator_tick_gen.sv - thermal update tick divider with restart
module incubator_tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [9:0] LAST = 10'(TICK_DIV - 1);

  logic [9:0] cnt_q;
  logic [9:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 10'd1;
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A restart swallows a coincident tick so the next one lands TICK_DIV edges later.
  assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/incubator_plant.sv
// rtl/incubator_plant.sv - first-order thermal model of an incubator chamber
module incubator_plant
  import incubator_pkg::*;
#(
  parameter int TICK_DIV  = 10,
  parameter int AMBIENT   = DEF_AMBIENT,
  parameter int HEAT_STEP = 2,
  parameter int INIT_TEMP = 25,
  parameter int T_MIN     = DEF_T_MIN,
  parameter int T_MAX     = DEF_T_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     heater,
  input  logic                     cooler,
  input  logic [3:0]               fan,
  input  logic                     load,
  input  logic signed [TEMP_W-1:0] load_value,
  output logic signed [TEMP_W-1:0] temperature,
  output logic                     sample_valid,
  output logic                     fault,
  output logic [1:0]               mode
);

  localparam logic signed [CALC_W-1:0] LO   = CALC_W'(T_MIN);
  localparam logic signed [CALC_W-1:0] HI   = CALC_W'(T_MAX);
  localparam logic signed [CALC_W-1:0] AMB  = CALC_W'(AMBIENT);
  localparam logic signed [CALC_W-1:0] STEP = CALC_W'(HEAT_STEP);
  localparam logic signed [CALC_W-1:0] ONE  = CALC_W'(1);

  logic tick;
  logic signed [TEMP_W-1:0] temp_q, temp_d;
  mode_t                    mode_q, mode_d;
  logic                     sample_valid_q, sample_valid_d;
  logic signed [CALC_W-1:0] t_ext, calc;
  logic [CALC_W-1:0]        cool_step;
  logic                     fan_unused;

  assign fan_unused = ^fan[1:0];

  incubator_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (load),
    .tick    (tick)
  );

  always_comb begin
    t_ext          = CALC_W'(temp_q);
    cool_step      = CALC_W'(1) + {{(CALC_W-2){1'b0}}, fan[3:2]};
    calc           = t_ext;
    mode_d         = mode_q;
    temp_d         = temp_q;
    sample_valid_d = 1'b0;
    if (load) begin
      temp_d = clamp_temp(CALC_W'(load_value), LO, HI);
    end else if (tick) begin
      sample_valid_d = 1'b1;
      if ((mode_q == MODE_FAULT) || (heater && cooler)) mode_d = MODE_FAULT;
      else if (heater)                                   mode_d = MODE_HEAT;
      else if (cooler)                                   mode_d = MODE_COOL;
      else                                               mode_d = MODE_DRIFT;
      // The update follows the state being entered on this edge, not the old one.
      case (mode_d)
        MODE_HEAT: calc = t_ext + STEP;
        MODE_COOL: calc = t_ext - $signed(cool_step);
        MODE_DRIFT: begin
          if (t_ext < AMB)      calc = t_ext + ONE;
          else if (t_ext > AMB) calc = t_ext - ONE;
        end
        default:   calc = t_ext;
      endcase
      temp_d = clamp_temp(calc, LO, HI);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_q         <= TEMP_W'(INIT_TEMP);
      mode_q         <= MODE_DRIFT;
      sample_valid_q <= 1'b0;
    end else begin
      temp_q         <= temp_d;
      mode_q         <= mode_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign temperature  = temp_q;
  assign sample_valid = sample_valid_q;
  assign mode         = mode_q;
  assign fault        = (mode_q == MODE_FAULT);

endmodule

// File: tb/tb_incubator_plant.sv
// tb/tb_incubator_plant.sv - randomized and directed checks against a behavioural plant model
module tb_incubator_plant;

  localparam int TD = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              heater = 1'b0;
  logic              cooler = 1'b0;
  logic [3:0]        fan = 4'd0;
  logic              load = 1'b0;
  logic signed [7:0] load_value = 8'sd0;
  logic signed [7:0] temperature;
  logic              sample_valid;
  logic              fault;
  logic [1:0]        mode;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int m_temp;
  int m_mode;
  int m_cnt;
  bit m_sv;

  incubator_plant #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .heater       (heater),
    .cooler       (cooler),
    .fan          (fan),
    .load         (load),
    .load_value   (load_value),
    .temperature  (temperature),
    .sample_valid (sample_valid),
    .fault        (fault),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v);
    if (v < -40) return -40;
    if (v > 100) return 100;
    return v;
  endfunction

  task automatic model_reset();
    m_temp = 25;
    m_mode = 0;
    m_cnt  = 0;
    m_sv   = 0;
  endtask

  // One rising edge of the plant as described by its rules, using the inputs held at that edge.
  task automatic model_edge();
    int f;
    f = int'(fan[3:2]);
    if (load) begin
      m_temp = clampi(int'(load_value));
      m_cnt  = 0;
      m_sv   = 0;
    end else if (m_cnt == TD - 1) begin
      m_cnt = 0;
      m_sv  = 1;
      if (m_mode != 3) m_mode = (heater && cooler) ? 3 : heater ? 1 : cooler ? 2 : 0;
      if (m_mode == 1)      m_temp = clampi(m_temp + 2);
      else if (m_mode == 2) m_temp = clampi(m_temp - 1 - f);
      else if (m_mode == 0) m_temp = m_temp + ((m_temp < 25) ? 1 : (m_temp > 25) ? -1 : 0);
    end else begin
      m_cnt = m_cnt + 1;
      m_sv  = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    heater = 0; cooler = 0; fan = 0; load = 0; load_value = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++; if (temperature !== 8'sd25) $display("FAIL reset_temp got %0d want 25", temperature); else pass_cnt++;
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL reset_sv got %b want 0", sample_valid); else pass_cnt++;
    total_cnt++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else pass_cnt++;
    total_cnt++; if (mode !== 2'd0) $display("FAIL reset_mode got %0d want 0", mode); else pass_cnt++;
  endtask

  task test_heat();
    int exp_t;
    do_reset();
    heater = 1;
    for (int e = 1; e <= 20; e++) begin
      step();
      exp_t = (e < 10) ? 25 : (e < 20) ? 27 : 29;
      total_cnt++; if (temperature !== 8'(exp_t)) $display("FAIL heat_temp edge %0d got %0d want %0d", e, temperature, exp_t); else pass_cnt++;
      total_cnt++; if (sample_valid !== ((e == 10) || (e == 20))) $display("FAIL heat_sv edge %0d got %b", e, sample_valid); else pass_cnt++;
    end
  endtask

  task test_cool();
    do_reset();
    step(); step();
    load = 1; load_value = 8'sd50;
    step();
    load = 0; cooler = 1; fan = 4'd8;
    total_cnt++; if (temperature !== 8'sd50) $display("FAIL cool_load got %0d want 50", temperature); else pass_cnt++;
    for (int k = 1; k <= 30; k++) begin
      if (k == 21) fan = 4'd15;
      step();
      total_cnt++; if (temperature !== 8'(m_temp)) $display("FAIL cool_model k %0d got %0d want %0d", k, temperature, m_temp); else pass_cnt++;
      if (k == 10) begin total_cnt++; if (temperature !== 8'sd47) $display("FAIL cool_first got %0d want 47", temperature); else pass_cnt++; end
      if (k == 20) begin total_cnt++; if (temperature !== 8'sd44) $display("FAIL cool_second got %0d want 44", temperature); else pass_cnt++; end
      if (k == 30) begin total_cnt++; if (temperature !== 8'sd40) $display("FAIL cool_fan15 got %0d want 40", temperature); else pass_cnt++; end
    end
  endtask

  task test_drift();
    int exp_t;
    do_reset();
    load = 1; load_value = 8'sd30;
    step();
    load = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k % 10 == 0) begin
        exp_t = (30 - k / 10 < 25) ? 25 : 30 - k / 10;
        total_cnt++; if (temperature !== 8'(exp_t)) $display("FAIL drift_down k %0d got %0d want %0d", k, temperature, exp_t); else pass_cnt++;
      end
    end
    load = 1; load_value = -8'sd5;
    step();
    load = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % 10 == 0) begin
        exp_t = -5 + k / 10;
        total_cnt++; if (temperature !== 8'(exp_t)) $display("FAIL drift_up k %0d got %0d want %0d", k, temperature, exp_t); else pass_cnt++;
      end
    end
  endtask

  task test_saturation();
    do_reset();
    load = 1; load_value = 8'sd99;
    step();
    load = 0; heater = 1;
    for (int k = 1; k <= 20; k++) step();
    total_cnt++; if (temperature !== 8'sd100) $display("FAIL sat_high got %0d want 100", temperature); else pass_cnt++;
    heater = 0;
    load = 1; load_value = -8'sd39;
    step();
    load = 0; cooler = 1; fan = 4'd15;
    step(); step(); step(); step(); step(); step(); step(); step(); step(); step();
    total_cnt++; if (temperature !== -8'sd40) $display("FAIL sat_low1 got %0d want -40", temperature); else pass_cnt++;
    for (int k = 1; k <= 10; k++) step();
    total_cnt++; if (temperature !== -8'sd40) $display("FAIL sat_low2 got %0d want -40", temperature); else pass_cnt++;
    cooler = 0;
    load = 1; load_value = 8'sd127;
    step();
    load = 0;
    total_cnt++; if (temperature !== 8'sd100) $display("FAIL sat_load127 got %0d want 100", temperature); else pass_cnt++;
    load = 1; load_value = -8'sd128;
    step();
    load = 0;
    total_cnt++; if (temperature !== -8'sd40) $display("FAIL sat_load_neg got %0d want -40", temperature); else pass_cnt++;
  endtask

  task test_fault();
    do_reset();
    heater = 1; cooler = 1;
    for (int k = 1; k <= 10; k++) step();
    total_cnt++; if (fault !== 1'b1) $display("FAIL fault_set got %b want 1", fault); else pass_cnt++;
    total_cnt++; if (mode !== 2'd3) $display("FAIL fault_mode got %0d want 3", mode); else pass_cnt++;
    total_cnt++; if (temperature !== 8'sd25) $display("FAIL fault_temp got %0d want 25", temperature); else pass_cnt++;
    heater = 0; cooler = 0;
    load = 1; load_value = 8'sd60;
    step();
    load = 0;
    total_cnt++; if (temperature !== 8'sd60 || fault !== 1'b1) $display("FAIL fault_load got %0d/%b want 60/1", temperature, fault); else pass_cnt++;
    for (int k = 1; k <= 30; k++) begin
      heater = k[0];
      step();
      total_cnt++; if (temperature !== 8'sd60 || mode !== 2'd3) $display("FAIL fault_hold k %0d got %0d/%0d want 60/3", k, temperature, mode); else pass_cnt++;
    end
    step(); step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (temperature !== 8'sd25 || fault !== 1'b0 || mode !== 2'd0) $display("FAIL fault_async_rst got %0d/%b/%0d want 25/0/0", temperature, fault, mode); else pass_cnt++;
    @(negedge clk);
    heater = 0;
    model_reset();
    rst = 1'b0;
  endtask

  task test_load_tick();
    do_reset();
    heater = 1;
    for (int k = 1; k <= 9; k++) step();
    load = 1; load_value = 8'sd40;
    step();
    load = 0;
    total_cnt++; if (temperature !== 8'sd40 || sample_valid !== 1'b0) $display("FAIL lt_load got %0d/%b want 40/0", temperature, sample_valid); else pass_cnt++;
    for (int k = 1; k <= 10; k++) begin
      step();
      total_cnt++; if (sample_valid !== (k == 10)) $display("FAIL lt_sv k %0d got %b", k, sample_valid); else pass_cnt++;
      total_cnt++; if (temperature !== ((k == 10) ? 8'sd42 : 8'sd40)) $display("FAIL lt_temp k %0d got %0d", k, temperature); else pass_cnt++;
    end
  endtask

  task test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      heater     = ($urandom_range(0, 2) == 0);
      cooler     = ($urandom_range(0, 3) == 0) && ($urandom_range(0, 5) == 0 || !heater);
      fan        = 4'($urandom_range(0, 15));
      load       = ($urandom_range(0, 24) == 0);
      load_value = 8'($urandom_range(0, 255));
      step();
      total_cnt++;
      if (temperature !== 8'(m_temp) || sample_valid !== m_sv || mode !== 2'(m_mode) || fault !== (m_mode == 3))
        $display("FAIL rand k %0d got t=%0d sv=%b m=%0d f=%b want t=%0d sv=%b m=%0d", k, temperature, sample_valid, mode, fault, m_temp, m_sv, m_mode);
      else pass_cnt++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_heat();
    test_cool();
    test_drift();
    test_saturation();
    test_fault();
    test_load_tick();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/incubator_plant.md
INCUBATOR_PLANT -- requirements
Module: incubator_plant

Interface
REQ-001 Parameter TICK_DIV, default 10: clock cycles per thermal update tick (range 2..1023).
REQ-002 Parameter AMBIENT, default 25: signed ambient temperature in degC.
REQ-003 Parameter HEAT_STEP, default 2: degC added per tick while heating.
REQ-004 Parameter INIT_TEMP, default 25: signed temperature after reset.
REQ-005 Parameter T_MIN, default -40; parameter T_MAX, default 100: signed saturation limits.
REQ-006 clk  input  1  single system clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 heater  input  1  heater drive from the controller.
REQ-009 cooler  input  1  cooler drive from the controller.
REQ-010 fan  input  4  fan speed level from the controller, unsigned.
REQ-011 load  input  1  forces the temperature to load_value (bench/test use).
REQ-012 load_value  input  8  signed two's-complement forced temperature.
REQ-013 temperature  output  8  signed two's-complement plant temperature; drives the controller input.
REQ-014 sample_valid  output  1  one-cycle pulse coincident with each tick-updated temperature.
REQ-015 fault  output  1  sticky flag: heater and cooler both asserted at a tick.
REQ-016 mode  output  2  current state encoding: DRIFT=0, HEAT=1, COOL=2, FAULT=3.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; a tick occurs on the edge where the count equals TICK_DIV-1.
REQ-018 First tick after reset release SHALL occur on the TICK_DIV-th rising edge.
REQ-019 heater, cooler and fan SHALL be sampled only on the tick edge; changes between ticks SHALL have no effect.
REQ-020 At a tick, the next state SHALL be: FAULT if already FAULT or heater&cooler; else HEAT if heater; else COOL if cooler; else DRIFT.
REQ-021 The temperature update at a tick SHALL use the next state from REQ-020 and SHALL take effect on the same edge.
REQ-022 HEAT: temperature SHALL become min(temperature + HEAT_STEP, T_MAX).
REQ-023 COOL: temperature SHALL become max(temperature - (1 + fan[3:2]), T_MIN), so the step is 1..4.
REQ-024 DRIFT: temperature SHALL move 1 toward AMBIENT and hold when equal to AMBIENT.
REQ-025 FAULT: temperature SHALL hold; fault=1 and mode=FAULT SHALL persist until rst, regardless of inputs.
REQ-026 Arithmetic SHALL use a 10-bit signed intermediate, and the result SHALL be clamped to [T_MIN, T_MAX] before registering, with no wrap-around.
REQ-027 sample_valid SHALL be 1 for exactly the cycle after each tick edge, including ticks where the value does not change.
REQ-028 On a load edge, temperature SHALL become load_value clamped to [T_MIN, T_MAX], and the tick counter SHALL restart at 0.
REQ-029 load SHALL take priority over a coincident tick: no thermal update occurs, sample_valid does not pulse, and the state is unchanged.
REQ-030 load in FAULT SHALL update temperature, and fault SHALL remain set.

Reset
REQ-031 While rst=1: temperature=INIT_TEMP, sample_valid=0, fault=0, mode=DRIFT, tick counter=0.
REQ-032 Assertion of rst mid-count or mid-FAULT SHALL take effect immediately, without waiting for a clock edge.

Structure
REQ-033 Shared package incubator_pkg SHALL hold the mode encodings DRIFT/HEAT/COOL/FAULT, the temperature width (8), and the default T_MIN/T_MAX/AMBIENT constants.
REQ-034 The tick counter SHALL be a sub-module incubator_tick_gen with ports clk, rst, restart, and tick, parameterised by TICK_DIV.

Verification
REQ-035 Reset release, heater=1, all others 0 -> temperature 25 then 27 on edge 10 and 29 on edge 20, with sample_valid pulsing once per tick.
REQ-036 load_value=50 at edge 3, then cooler=1, fan=8 -> 47 ten edges after the load, then 44; with fan=15 -> steps of 4.
REQ-037 load_value=30, then all inputs 0 -> 29, 28, 27, 26, 25, then holds 25; load_value=-5 drifts upward -5 -> -4 and onward.
REQ-038 load_value=99 with heater=1 -> 100 and holds; load_value=-39 with cooler=1, fan=15 -> -40 and holds; load_value=127 with T_MAX=100 -> 100.
REQ-039 heater=cooler=1 at a tick -> fault=1, mode=3, and temperature frozen; after both drop, temperature stays frozen across 3 ticks; rst pulse mid-count -> 25 and fault=0 immediately.
REQ-040 load asserted on a tick edge -> load value taken, no sample_valid pulse, and the next tick occurs TICK_DIV edges later.
